bcd_seq_ctrl: RTL
=================

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 SHALL have ports (clock and reset first):
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- num  input  32  binary operand; sampled with start.
- is_signed  input  1  1 = num is two's complement; sampled with start.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle result-valid pulse.
- bcd  output  40  ten BCD digits; bcd[3:0] = units, bcd[39:36] = 10^9.
- ndigits  output  4  count of significant digits, 1..10.
- neg  output  1  result is negative (signed mode only).
REQ-002 SHALL have no parameters; widths are fixed at 32-bit input and 10-digit output.

Function
REQ-003 SHALL implement an iterative double-dabble converter with one shift per clock and an FSM with states IDLE, SHIFT and FIN.
REQ-004 In IDLE, when start=1 at edge k:
- capture magnitude = (is_signed && num[31]) ? (~num + 1) : num;
- capture neg_pending = is_signed && num[31];
- clear the internal 40-bit working BCD register and the 6-bit iteration counter;
- go to SHIFT and set busy=1.
REQ-005 The magnitude for num=0x80000000 signed SHALL be 2147483648, treated as unsigned 32-bit with no overflow.
REQ-006 Each SHIFT cycle SHALL perform the following, MSB of the magnitude first:
- add 3 to every working digit greater than 4;
- shift the working digits plus magnitude left by one bit;
- increment the counter.
REQ-007 After exactly 32 SHIFT cycles (edges k+1..k+32) the FSM SHALL enter FIN.
REQ-008 At edge k+33 (leaving FIN) the block SHALL:
- load bcd from the working register;
- load neg from neg_pending, forced to 0 if the magnitude was 0;
- load ndigits = index of the highest nonzero digit + 1, or 1 if all digits are zero;
- set done=1 and busy=0;
- return to IDLE.
REQ-009 done SHALL be high for exactly one cycle (edge k+33 to k+34); total latency from the start edge to the done edge is 33 clocks.
REQ-010 bcd, ndigits and neg SHALL hold their last values until the next FIN update; they SHALL NOT change during SHIFT.
REQ-011 start while busy=1 SHALL be ignored, with no queuing and no effect on the running conversion.
REQ-012 start in the cycle where done=1 SHALL be accepted, since the FSM is already in IDLE; done still deasserts at the next edge, and back-to-back conversions run every 34 cycles.
REQ-013 num and is_signed changes after the start edge SHALL have no effect on the running conversion.
REQ-014 With is_signed=0, neg SHALL always be 0 and num[31] SHALL be treated as magnitude.
REQ-015 Digit add-3 and shift SHALL be 4-bit modular per digit; no valid input (max 4294967295) produces a digit above 9.

Reset
REQ-016 While rst=1, and immediately on its assertion:
- FSM=IDLE, busy=0, done=0, bcd=0, ndigits=1, neg=0;
- counter, working register and captured magnitude cleared.
REQ-017 Reset asserted mid-conversion SHALL abort it with no done pulse; the first start after rst deasserts SHALL be processed normally.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Unsigned num=0 -> done 33 clocks after the start edge; bcd=0, ndigits=1, neg=0.
- Unsigned num=0xFFFFFFFF -> bcd=0x4294967295, ndigits=10, neg=0; the same num with is_signed=1 -> bcd=1, ndigits=1, neg=1.
- Signed num=0x80000000 -> bcd=0x2147483648, ndigits=10, neg=1.
- Start num=12345; pulse start with num=999 at cycle 10 -> that start is ignored, result is bcd=0x12345 with ndigits=5; then start num=907 in the done cycle -> second done 34 clocks later with bcd=0x907, ndigits=3.
- Start num=55; assert rst at cycle 20 -> busy=0 and bcd=0 immediately, no done pulse; after release, start num=7 -> bcd=0x7, ndigits=1.
- Random unsigned and signed operands checked against a reference model for bcd, ndigits, neg and the 33-clock latency, with busy/done assertions checked throughout.

Source files
------------

// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (double dabble, one shift per clock).
// Accepts a 32-bit operand, optionally two's complement, and produces ten
// BCD digits, the count of significant digits and a sign flag 33 clocks
// after the start edge.
module bcd_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] num,
  input  logic        is_signed,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd,
  output logic [3:0]  ndigits,
  output logic        neg
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [39:0] work_q, work_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        negp_q, negp_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [39:0] bcd_q, bcd_d;
  logic [3:0]  ndig_q, ndig_d;
  logic        neg_q, neg_d;

  logic [39:0] adj;
  logic [3:0]  nd_calc;

  // Per-digit add-3 correction (4-bit wrap) ahead of the shift.
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (work_q[4*i +: 4] > 4'd4) begin
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = work_q[4*i +: 4];
      end
    end
  end

  // Significant-digit count: highest nonzero digit index + 1, minimum 1.
  always_comb begin
    nd_calc = 4'd1;
    for (int unsigned i = 0; i < 10; i++) begin
      if (work_q[4*i +: 4] != 4'd0) begin
        nd_calc = 4'(i + 1);
      end
    end
  end

  // Next-state and next-output logic for the IDLE/SHIFT/FIN sequencer.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    negp_d  = negp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mag_d   = (is_signed && num[31]) ? (~num + 32'd1) : num;
          negp_d  = is_signed && num[31];
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Corrected digits and remaining magnitude shift as one 72-bit word.
        {work_d, mag_d} = {adj, mag_q} << 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FIN;
        end
      end
      FIN: begin
        bcd_d   = work_q;
        // A zero result never reports negative.
        neg_d   = negp_q && (work_q != '0);
        ndig_d  = nd_calc;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset aborts any conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      negp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ndig_q  <= 4'd1;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      negp_q  <= negp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ndig_q  <= ndig_d;
      neg_q   <= neg_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign ndigits = ndig_q;
  assign neg     = neg_q;

endmodule
